// File: rtl/ptw_arb.sv
// ptw_arb - arbitrates ITLB and DTLB page-walk requests onto a single shared
// page-table walker (PTW), one walk outstanding at a time.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   Itlb_pa_request/Itlb_va        ITLB walk request pulse + VA
//   Itlb_flush                     drop pending ITLB walk, discard in-flight one
//   Dtlb_pa_request/Dtlb_va        DTLB walk request pulse + VA
//   ptw_req/ptw_va                 one-cycle PTW request, VA held during walk
//   ptw_valid/ptw_pa               PTW result pulse + PPN
//   F_ptw_valid/F_ptw_pa           ITLB response pulse + PPN
//   M_ptw_valid/M_ptw_pa           DTLB response pulse + PPN
//   ptw_timeout                    one-cycle pulse when a walk is aborted
module ptw_arb #(
   parameter int VA_WIDTH  = 20,
   parameter int PPN_WIDTH = 8,
   parameter int TIMEOUT   = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 Itlb_pa_request,
   input  logic [VA_WIDTH-1:0]  Itlb_va,
   input  logic                 Itlb_flush,
   input  logic                 Dtlb_pa_request,
   input  logic [VA_WIDTH-1:0]  Dtlb_va,
   output logic                 ptw_req,
   output logic [VA_WIDTH-1:0]  ptw_va,
   input  logic                 ptw_valid,
   input  logic [PPN_WIDTH-1:0] ptw_pa,
   output logic                 F_ptw_valid,
   output logic [PPN_WIDTH-1:0] F_ptw_pa,
   output logic                 M_ptw_valid,
   output logic [PPN_WIDTH-1:0] M_ptw_pa,
   output logic                 ptw_timeout
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t              state, state_nxt;
   logic                i_pend, d_pend;
   logic [VA_WIDTH-1:0] i_va, d_va;
   logic                owner_i;   // 1: ITLB owns the walk, 0: DTLB
   logic                last_i;    // 1: ITLB was granted last
   logic                discard;
   logic [CW-1:0]       cnt;
   logic                take, grant_i, timeout_hit, in_flight;

   // Round-robin: ITLB wins alone, or on a tie when DTLB was granted last.
   assign grant_i     = i_pend && (!d_pend || !last_i);
   assign take        = (state == IDLE) && (i_pend || d_pend);
   assign in_flight   = (state == ISSUE) || (state == WAIT);
   assign timeout_hit = (state == WAIT) && !ptw_valid && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      ptw_req     = 1'b0;
      F_ptw_valid = 1'b0;
      M_ptw_valid = 1'b0;
      case (state)
         IDLE:  if (i_pend || d_pend) state_nxt = ISSUE;
         ISSUE: begin
            ptw_req   = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (ptw_valid)        state_nxt = RESP;
            else if (timeout_hit) state_nxt = IDLE;
         end
         RESP: begin
            F_ptw_valid = owner_i && !discard;
            M_ptw_valid = !owner_i;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_pend      <= 1'b0;
         d_pend      <= 1'b0;
         i_va        <= '0;
         d_va        <= '0;
         owner_i     <= 1'b0;
         last_i      <= 1'b0;
         discard     <= 1'b0;
         cnt         <= '0;
         ptw_va      <= '0;
         F_ptw_pa    <= '0;
         M_ptw_pa    <= '0;
         ptw_timeout <= 1'b0;
      end else begin
         // A fresh request beats both flush and grant: it is a new walk.
         if (Itlb_pa_request)         i_pend <= 1'b1;
         else if (Itlb_flush)         i_pend <= 1'b0;
         else if (take && grant_i)    i_pend <= 1'b0;

         if (Dtlb_pa_request)         d_pend <= 1'b1;
         else if (take && !grant_i)   d_pend <= 1'b0;

         if (Itlb_pa_request) i_va <= Itlb_va;
         if (Dtlb_pa_request) d_va <= Dtlb_va;

         if (take) begin
            owner_i <= grant_i;
            last_i  <= grant_i;
            ptw_va  <= grant_i ? i_va : d_va;
         end

         // A flush landing on the grant cycle still kills the ITLB walk.
         if (take)
            discard <= grant_i && Itlb_flush;
         else if (Itlb_flush && owner_i && in_flight)
            discard <= 1'b1;

         if (state != WAIT)  cnt <= '0;
         else if (!ptw_valid) cnt <= cnt + 1'b1;

         if (state == WAIT && ptw_valid) begin
            if (owner_i && !discard) F_ptw_pa <= ptw_pa;
            if (!owner_i)            M_ptw_pa <= ptw_pa;
         end

         ptw_timeout <= timeout_hit;
      end
   end

endmodule

// File: tb/tb_ptw_arb.sv
// tb_ptw_arb - directed self-checking bench for ptw_arb with a simple
// fixed-latency PTW model. Inputs are driven and outputs observed on the
// falling clock edge; cycle numbers count falling edges.
module tb_ptw_arb;

   logic        clk, rst_n;
   logic        Itlb_pa_request, Itlb_flush, Dtlb_pa_request;
   logic [19:0] Itlb_va, Dtlb_va;
   logic        ptw_req, ptw_valid;
   logic [19:0] ptw_va;
   logic [7:0]  ptw_pa, F_ptw_pa, M_ptw_pa;
   logic        F_ptw_valid, M_ptw_valid, ptw_timeout;

   ptw_arb #(.VA_WIDTH(20), .PPN_WIDTH(8), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .Itlb_pa_request(Itlb_pa_request), .Itlb_va(Itlb_va), .Itlb_flush(Itlb_flush),
      .Dtlb_pa_request(Dtlb_pa_request), .Dtlb_va(Dtlb_va),
      .ptw_req(ptw_req), .ptw_va(ptw_va), .ptw_valid(ptw_valid), .ptw_pa(ptw_pa),
      .F_ptw_valid(F_ptw_valid), .F_ptw_pa(F_ptw_pa),
      .M_ptw_valid(M_ptw_valid), .M_ptw_pa(M_ptw_pa),
      .ptw_timeout(ptw_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int cyc = 0, lat = 3, cd = 0, both_cnt = 0;
   int req_cyc[$], f_cyc[$], m_cyc[$], to_cyc[$];
   logic [19:0] req_va[$];
   logic [7:0]  f_pa[$], m_pa[$];
   int c0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_log();
      req_cyc.delete(); f_cyc.delete(); m_cyc.delete(); to_cyc.delete();
      req_va.delete(); f_pa.delete(); m_pa.delete();
   endtask

   // One cycle: observe outputs, drop last cycle's pulses, run the PTW model.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (ptw_req)     begin req_cyc.push_back(cyc); req_va.push_back(ptw_va); end
      if (F_ptw_valid) begin f_cyc.push_back(cyc); f_pa.push_back(F_ptw_pa); end
      if (M_ptw_valid) begin m_cyc.push_back(cyc); m_pa.push_back(M_ptw_pa); end
      if (ptw_timeout) to_cyc.push_back(cyc);
      if (F_ptw_valid && M_ptw_valid) both_cnt++;
      Itlb_pa_request = 1'b0;
      Dtlb_pa_request = 1'b0;
      Itlb_flush      = 1'b0;
      ptw_valid       = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) ptw_valid = 1'b1;
      end
      if (ptw_req && lat > 0) cd = lat;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cd    = 0;
      run(2);
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      Itlb_pa_request = 1'b0; Dtlb_pa_request = 1'b0; Itlb_flush = 1'b0;
      Itlb_va = '0; Dtlb_va = '0; ptw_valid = 1'b0; ptw_pa = '0;
      #3;
      chk("rst_outs", {ptw_req, F_ptw_valid, M_ptw_valid, ptw_timeout}, 0);
      chk("rst_va", ptw_va, 0);
      chk("rst_pa", {F_ptw_pa, M_ptw_pa}, 0);
      run(2);
      rst_n = 1'b1;
      run(2);

      // Single ITLB walk, latency 3, result 0x45.
      clr_log(); lat = 3; ptw_pa = 8'h45;
      step(); c0 = cyc;
      Itlb_pa_request = 1'b1; Itlb_va = 20'h12345;
      run(10);
      chk("t1_req_cnt", req_cyc.size(), 1);
      chk("t1_req_lat", req_cyc[0] - c0, 2);
      chk("t1_req_va", req_va[0], 20'h12345);
      chk("t1_f_cnt", f_cyc.size(), 1);
      chk("t1_f_lat", f_cyc[0] - c0, 6);
      chk("t1_f_pa", f_pa[0], 8'h45);
      chk("t1_m_cnt", m_cyc.size(), 0);

      // Tie from reset: ITLB first, then DTLB.
      do_reset(); clr_log(); ptw_pa = 8'h77;
      step(); c0 = cyc;
      Itlb_pa_request = 1'b1; Itlb_va = 20'h00100;
      Dtlb_pa_request = 1'b1; Dtlb_va = 20'h00200;
      run(16);
      chk("t2_req_cnt", req_cyc.size(), 2);
      chk("t2_va0", req_va[0], 20'h00100);
      chk("t2_va1", req_va[1], 20'h00200);
      chk("t2_req1_lat", req_cyc[1] - c0, 8);
      chk("t2_f_cnt", f_cyc.size(), 1);
      chk("t2_m_cnt", m_cyc.size(), 1);
      chk("t2_f_lat", f_cyc[0] - c0, 6);
      chk("t2_m_lat", m_cyc[0] - c0, 12);
      chk("t2_m_pa", m_pa[0], 8'h77);

      // Flush in WAIT of an ITLB walk; pending DTLB served next.
      clr_log(); ptw_pa = 8'h3c;
      step(); c0 = cyc;
      Itlb_pa_request = 1'b1; Itlb_va = 20'h00400;
      run(3);
      Itlb_flush = 1'b1;
      Dtlb_pa_request = 1'b1; Dtlb_va = 20'h00500;
      run(14);
      chk("t3_req_cnt", req_cyc.size(), 2);
      chk("t3_va1", req_va[1], 20'h00500);
      chk("t3_req1_lat", req_cyc[1] - c0, 8);
      chk("t3_f_cnt", f_cyc.size(), 0);
      chk("t3_m_cnt", m_cyc.size(), 1);
      chk("t3_m_pa", m_pa[0], 8'h3c);

      // PTW never answers: timeout 16 cycles after ptw_req, late valid ignored.
      clr_log(); lat = 0; ptw_pa = 8'h99;
      step(); c0 = cyc;
      Dtlb_pa_request = 1'b1; Dtlb_va = 20'h00600;
      run(20);
      chk("t4_to_cnt", to_cyc.size(), 1);
      chk("t4_to_lat", to_cyc[0] - req_cyc[0], 16);
      ptw_valid = 1'b1;
      run(6);
      chk("t4_req_cnt", req_cyc.size(), 1);
      chk("t4_resp_cnt", f_cyc.size() + m_cyc.size(), 0);
      chk("t4_m_pa_hold", M_ptw_pa, 8'h3c);

      // Async reset mid-WAIT, then a normal DTLB walk.
      clr_log();
      step();
      Dtlb_pa_request = 1'b1; Dtlb_va = 20'h00700;
      run(3);
      chk("t5_va_pre", ptw_va, 20'h00700);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_outs", {ptw_req, F_ptw_valid, M_ptw_valid, ptw_timeout}, 0);
      chk("t5_rst_va", ptw_va, 0);
      chk("t5_rst_pa", {F_ptw_pa, M_ptw_pa}, 0);
      step();
      rst_n = 1'b1;
      clr_log(); lat = 2; ptw_pa = 8'h5a;
      step(); c0 = cyc;
      Dtlb_pa_request = 1'b1; Dtlb_va = 20'h00800;
      run(8);
      chk("t5_req_cnt", req_cyc.size(), 1);
      chk("t5_req_va", req_va[0], 20'h00800);
      chk("t5_m_lat", m_cyc[0] - c0, 5);
      chk("t5_m_pa", m_pa[0], 8'h5a);

      // DTLB re-requests during its own WAIT: second walk with new VA.
      clr_log(); lat = 3; ptw_pa = 8'h21;
      step(); c0 = cyc;
      Dtlb_pa_request = 1'b1; Dtlb_va = 20'h00300;
      run(3);
      Dtlb_pa_request = 1'b1; Dtlb_va = 20'h00301;
      run(14);
      chk("t6_req_cnt", req_cyc.size(), 2);
      chk("t6_va1", req_va[1], 20'h00301);
      chk("t6_m_cnt", m_cyc.size(), 2);
      chk("t6_m0_lat", m_cyc[0] - c0, 6);
      chk("t6_m1_lat", m_cyc[1] - c0, 12);

      chk("never_both", both_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
